// File: rtl/pacman_collision_ctrl_if.sv
// Bus between the game top level and the collision controller: sprite positions in, HUD/ghost status out.
// Build option GHOST_HIT_ID_EN adds the hit_ghost_id status field.
interface pacman_collision_ctrl_if;
    logic       hasMoved;
    logic [9:0] pacmanX;
    logic [9:0] pacmanY;
    logic [9:0] ghost_redX;
    logic [9:0] ghost_redY;
    logic [9:0] ghost_greenX;
    logic [9:0] ghost_greenY;
    logic [9:0] ghost_aquaX;
    logic [9:0] ghost_aquaY;
    logic       isDefeated;
    logic [1:0] lives;
    logic       respawn_req;
    logic       game_over;
`ifdef GHOST_HIT_ID_EN
    logic [1:0] hit_ghost_id;
`endif

    // Game top level: supplies positions, consumes status.
    modport master (
        output hasMoved, pacmanX, pacmanY,
        output ghost_redX, ghost_redY, ghost_greenX, ghost_greenY, ghost_aquaX, ghost_aquaY,
        input  isDefeated, lives, respawn_req, game_over
`ifdef GHOST_HIT_ID_EN
        , input hit_ghost_id
`endif
    );

    // Collision controller: consumes positions, drives status.
    modport slave (
        input  hasMoved, pacmanX, pacmanY,
        input  ghost_redX, ghost_redY, ghost_greenX, ghost_greenY, ghost_aquaX, ghost_aquaY,
        output isDefeated, lives, respawn_req, game_over
`ifdef GHOST_HIT_ID_EN
        , output hit_ghost_id
`endif
    );
endinterface

// File: rtl/pacman_collision_ctrl.sv
// Pac-Man vs ghost collision detector and life/freeze/respawn FSM, one update per frame_clk edge.
// Build option GHOST_HIT_ID_EN records which ghost caused the last catch (1=red, 2=green, 3=aqua).
module pacman_collision_ctrl #(
    parameter int HIT_DIST      = 8,
    parameter int FREEZE_FRAMES = 60,
    parameter int LIVES_INIT    = 3
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    pacman_collision_ctrl_if.slave  bus
);

    localparam int CNT_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HIT,
        S_RESPAWN,
        S_OVER
    } state_t;

    // Distances are taken as true signed differences so a sprite at the far edge
    // never aliases onto one at the near edge.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[10] ? 11'(-d) : 11'(d);
    endfunction

    function automatic logic near(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] gx, input logic [9:0] gy);
        return (abs_diff(px, gx) < 11'(HIT_DIST)) && (abs_diff(py, gy) < 11'(HIT_DIST));
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    logic hit_red, hit_green, hit_aqua, any_hit;

    assign hit_red   = near(bus.pacmanX, bus.pacmanY, bus.ghost_redX,   bus.ghost_redY);
    assign hit_green = near(bus.pacmanX, bus.pacmanY, bus.ghost_greenX, bus.ghost_greenY);
    assign hit_aqua  = near(bus.pacmanX, bus.pacmanY, bus.ghost_aquaX,  bus.ghost_aquaY);
    assign any_hit   = hit_red | hit_green | hit_aqua;

`ifdef GHOST_HIT_ID_EN
    logic [1:0] hit_id_q, hit_id_d;
    logic [1:0] first_hit_id;

    always_comb begin
        if (hit_red)        first_hit_id = 2'd1;
        else if (hit_green) first_hit_id = 2'd2;
        else if (hit_aqua)  first_hit_id = 2'd3;
        else                first_hit_id = 2'd0;
    end
`endif

    // NOTE: every variable is given a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        freeze_cnt_d = freeze_cnt_q;
`ifdef GHOST_HIT_ID_EN
        hit_id_d     = hit_id_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.hasMoved) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (any_hit) begin
                    state_d      = S_HIT;
                    lives_d      = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    freeze_cnt_d = CNT_W'(FREEZE_FRAMES - 1);
`ifdef GHOST_HIT_ID_EN
                    hit_id_d     = first_hit_id;
`endif
                end
            end
            S_HIT: begin
                if (freeze_cnt_q == '0) begin
                    state_d = (lives_q == 2'd0) ? S_OVER : S_RESPAWN;
                end else begin
                    freeze_cnt_d = freeze_cnt_q - CNT_W'(1);
                end
            end
            S_RESPAWN: state_d = S_IDLE;
            S_OVER:    state_d = S_OVER;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: Reset is synchronous and checked first, so it overrides HIT and OVER
    // on the very edge it is sampled; state uses non-blocking assignments so all
    // flops update together from the values computed before the edge.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            lives_q      <= 2'(LIVES_INIT);
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

`ifdef GHOST_HIT_ID_EN
    always_ff @(posedge frame_clk) begin
        if (Reset) hit_id_q <= 2'd0;
        else       hit_id_q <= hit_id_d;
    end

    assign bus.hit_ghost_id = hit_id_q;
`endif

    // Outputs are decoded from the registered state only.
    assign bus.isDefeated  = (state_q == S_HIT) || (state_q == S_OVER);
    assign bus.respawn_req = (state_q == S_RESPAWN);
    assign bus.game_over   = (state_q == S_OVER);
    assign bus.lives       = lives_q;

endmodule

// File: tb/tb_pacman_collision_ctrl.sv
// Directed bench for pacman_collision_ctrl (HIT_DIST=8, FREEZE_FRAMES=4, LIVES_INIT=3).
// Checks hit_ghost_id only when built with GHOST_HIT_ID_EN.
module tb_pacman_collision_ctrl;

    localparam logic [9:0] FAR = 10'd500;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    pacman_collision_ctrl_if bus ();

    pacman_collision_ctrl #(
        .HIT_DIST      (8),
        .FREEZE_FRAMES (4),
        .LIVES_INIT    (3)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       hm;
        logic [9:0] px, py, rx, ry, gx, gy, ax, ay;
        logic       exp_def;
        logic [1:0] exp_lives;
        logic       exp_rsp;
        logic       exp_go;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(string name, logic rst, logic hm,
                                logic [9:0] px, logic [9:0] py, logic [9:0] rx, logic [9:0] ry,
                                logic [9:0] gx, logic [9:0] gy, logic [9:0] ax, logic [9:0] ay,
                                logic def, logic [1:0] lv, logic rsp, logic go, logic [1:0] id);
        vec_t v;
        v.name = name; v.rst = rst; v.hm = hm;
        v.px = px; v.py = py; v.rx = rx; v.ry = ry;
        v.gx = gx; v.gy = gy; v.ax = ax; v.ay = ay;
        v.exp_def = def; v.exp_lives = lv; v.exp_rsp = rsp; v.exp_go = go; v.exp_id = id;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic def, input logic [1:0] lv,
                             input logic rsp, input logic go, input logic [1:0] id);
        check({tag, ".isDefeated"},  32'(bus.isDefeated),  32'(def));
        check({tag, ".lives"},       32'(bus.lives),       32'(lv));
        check({tag, ".respawn_req"}, 32'(bus.respawn_req), 32'(rsp));
        check({tag, ".game_over"},   32'(bus.game_over),   32'(go));
`ifdef GHOST_HIT_ID_EN
        check({tag, ".hit_ghost_id"}, 32'(bus.hit_ghost_id), 32'(id));
`else
        if (id > 2'd3) $display("unexpected id");
`endif
    endtask

    task automatic set_pos(input logic [9:0] px, input logic [9:0] py,
                           input logic [9:0] rx, input logic [9:0] ry,
                           input logic [9:0] gx, input logic [9:0] gy,
                           input logic [9:0] ax, input logic [9:0] ay);
        bus.pacmanX = px;      bus.pacmanY = py;
        bus.ghost_redX = rx;   bus.ghost_redY = ry;
        bus.ghost_greenX = gx; bus.ghost_greenY = gy;
        bus.ghost_aquaX = ax;  bus.ghost_aquaY = ay;
    endtask

    task automatic all_far();
        set_pos(10'd100, 10'd100, FAR, FAR, FAR, FAR, FAR, FAR);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.hasMoved = 1'b0;
        all_far();
        tick();
        Reset = 1'b0;
    endtask

    // Remaining three HIT frames, then the exit frame (RESPAWN or OVER).
    task automatic finish_freeze(input string tag, input logic [1:0] lv,
                                 input logic to_over, input logic [1:0] id);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all({tag, ".freeze"}, 1'b1, lv, 1'b0, 1'b0, id);
        end
        tick();
        if (to_over) check_all({tag, ".over"},    1'b1, lv, 1'b0, 1'b1, id);
        else         check_all({tag, ".respawn"}, 1'b0, lv, 1'b1, 1'b0, id);
    endtask

    initial begin
        bus.hasMoved = 1'b0;
        all_far();

        // Scenarios 1-3 as a cycle-by-cycle script: inputs before the edge, outputs after it.
        vecs[0]  = mk("reset",        1, 0, 100,100, 100,100, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[1]  = mk("idle_ign_hit", 0, 0, 100,100, 100,100, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[2]  = mk("idle_hold",    0, 0, 100,100, 100,100, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[3]  = mk("go_play",      0, 1, 100,100, FAR,FAR, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[4]  = mk("dx_eq_8",      0, 0, 100,100, 108,100, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[5]  = mk("dy_eq_8",      0, 0, 100,100, 100, 92, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[6]  = mk("no_wrap",      0, 0,   0,  0, 1020, 0, FAR,FAR, FAR,FAR, 0,3,0,0,0);
        vecs[7]  = mk("catch_dx7",    0, 0, 100,100, 107,100, FAR,FAR, FAR,FAR, 1,2,0,0,1);
        vecs[8]  = mk("hit_f2",       0, 0, 100,100, 107,100, FAR,FAR, FAR,FAR, 1,2,0,0,1);
        vecs[9]  = mk("hit_f3",       0, 0, 100,100, 107,100, FAR,FAR, FAR,FAR, 1,2,0,0,1);
        vecs[10] = mk("hit_f4",       0, 0, 100,100, 107,100, FAR,FAR, FAR,FAR, 1,2,0,0,1);
        vecs[11] = mk("respawn",      0, 0, 100,100, FAR,FAR, FAR,FAR, FAR,FAR, 0,2,1,0,1);
        vecs[12] = mk("back_idle",    0, 0, 100,100, FAR,FAR, FAR,FAR, FAR,FAR, 0,2,0,0,1);
        vecs[13] = mk("idle_stays",   0, 0, 100,100, 100,100, FAR,FAR, FAR,FAR, 0,2,0,0,1);

        foreach (vecs[i]) begin
            Reset        = vecs[i].rst;
            bus.hasMoved = vecs[i].hm;
            set_pos(vecs[i].px, vecs[i].py, vecs[i].rx, vecs[i].ry,
                    vecs[i].gx, vecs[i].gy, vecs[i].ax, vecs[i].ay);
            tick();
            check_all(vecs[i].name, vecs[i].exp_def, vecs[i].exp_lives,
                      vecs[i].exp_rsp, vecs[i].exp_go, vecs[i].exp_id);
        end

        // Simultaneous catches cost one life; priority selects the ghost id.
        do_reset();
        bus.hasMoved = 1'b1;
        tick();
        check_all("s4.play", 0, 3, 0, 0, 0);
        set_pos(100, 100, 100, 100, 100, 100, 100, 100);
        tick();
        check_all("s4.triple", 1, 2, 0, 0, 1);
        all_far();
        finish_freeze("s4a", 2, 0, 1);
        tick();
        check_all("s4.idle", 0, 2, 0, 0, 1);
        tick();
        set_pos(100, 100, FAR, FAR, 93, 100, 100, 107);
        tick();
        check_all("s4.green_aqua", 1, 1, 0, 0, 2);
        all_far();
        finish_freeze("s4b", 1, 0, 2);

        // Third catch reaches OVER, which absorbs everything but Reset.
        tick();
        tick();
        set_pos(100, 100, 100, 100, FAR, FAR, FAR, FAR);
        tick();
        check_all("s5.last_catch", 1, 0, 0, 0, 1);
        finish_freeze("s5", 0, 1, 1);
        set_pos(100, 100, 100, 100, 100, 100, 100, 100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("s5.over_held", 1, 0, 0, 1, 1);
        end
        Reset = 1'b1;
        tick();
        check_all("s5.reset", 0, 3, 0, 0, 0);
        Reset = 1'b0;

        // Reset in the middle of HIT: reset values, and no respawn pulse afterwards.
        do_reset();
        bus.hasMoved = 1'b1;
        tick();
        set_pos(100, 100, 100, 100, FAR, FAR, FAR, FAR);
        tick();
        check_all("s6.hit", 1, 2, 0, 0, 1);
        tick();
        check_all("s6.cnt2", 1, 2, 0, 0, 1);
        Reset = 1'b1;
        tick();
        check_all("s6.reset", 0, 3, 0, 0, 0);
        Reset = 1'b0;
        bus.hasMoved = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all("s6.quiet", 0, 3, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
